// File: rtl/ft_stream_demux.sv
// ft_stream_demux: routes FTDI packets to one of NUM_CH IQ sample FIFOs
// or the CPU port. It decodes a header word, then forwards exactly N payload words.
//
// Ports:
//   clk_i, reset_n        clock and synchronous active-low reset
//   data_i, we_i          FTDI word and its valid strobe
//   full_o, enough_o      status of the selected destination (combinational)
//   fifo_full_i/enough_i  per-channel FIFO status
//   fifo_data_o/we_o      packed IQ word shared by all FIFOs, one-hot strobe
//   cpu_full_i            CPU port full
//   cpu_data_o/we_o       CPU port data and strobe
//   cnt_clr_i             clear of both counters
//   busy_o, cur_ch_o      packet in progress, channel of the last header
//   drop_cnt_o            packets discarded for a bad channel, saturating
//   ovf_cnt_o             payload words lost to a full destination, saturating
module ft_stream_demux #(
   parameter int FT_DATA_WIDTH    = 32,
   parameter int IQ_PAIR_WIDTH    = 24,
   parameter int QSTART_BIT_INDEX = 16,
   parameter int NUM_CH           = 4,
   parameter int LEN_WIDTH        = 16,
   parameter int CNT_WIDTH        = 8
) (
   input  logic                     clk_i,
   input  logic                     reset_n,
   input  logic [FT_DATA_WIDTH-1:0] data_i,
   input  logic                     we_i,
   output logic                     full_o,
   output logic                     enough_o,
   input  logic [NUM_CH-1:0]        fifo_full_i,
   input  logic [NUM_CH-1:0]        fifo_enough_i,
   output logic [IQ_PAIR_WIDTH-1:0] fifo_data_o,
   output logic [NUM_CH-1:0]        fifo_we_o,
   input  logic                     cpu_full_i,
   output logic [FT_DATA_WIDTH-1:0] cpu_data_o,
   output logic                     cpu_we_o,
   input  logic                     cnt_clr_i,
   output logic                     busy_o,
   output logic [2:0]               cur_ch_o,
   output logic [CNT_WIDTH-1:0]     drop_cnt_o,
   output logic [CNT_WIDTH-1:0]     ovf_cnt_o
);

   localparam int HALF = IQ_PAIR_WIDTH / 2;

   typedef enum logic [1:0] {
      IDLE,
      FIFO_PL,
      CPU_PL,
      DISCARD
   } state_t;

   state_t                   state_q, state_d;
   logic [LEN_WIDTH-1:0]     rem_q, rem_d;
   logic [2:0]               ch_q, ch_d;
   logic [NUM_CH-1:0]        fifo_we_q, fifo_we_d;
   logic                     cpu_we_q, cpu_we_d;
   logic [IQ_PAIR_WIDTH-1:0] fifo_data_q;
   logic [FT_DATA_WIDTH-1:0] cpu_data_q;
   logic [CNT_WIDTH-1:0]     drop_q, ovf_q;
   logic                     drop_inc, ovf_inc;

   logic                     hdr_cpu;
   logic [2:0]               hdr_ch;
   logic [LEN_WIDTH-1:0]     hdr_len;
   logic                     hdr_bad;
   logic                     last_word;
   logic [NUM_CH-1:0]        ch_oh;
   logic                     sel_full;
   logic                     sel_enough;

   assign hdr_cpu   = data_i[FT_DATA_WIDTH-1];
   assign hdr_ch    = data_i[FT_DATA_WIDTH-2:FT_DATA_WIDTH-4];
   assign hdr_len   = data_i[LEN_WIDTH-1:0];
   // Widened compare so NUM_CH=8 does not wrap to zero.
   assign hdr_bad   = {1'b0, hdr_ch} >= 4'(NUM_CH);
   assign last_word = rem_q == LEN_WIDTH'(1);

   // One-hot decode of the latched channel; avoids indexing a
   // NUM_CH-wide vector with a 3-bit channel field.
   always_comb begin
      ch_oh = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (ch_q == 3'(i)) begin
            ch_oh[i] = 1'b1;
         end
      end
   end

   assign sel_full   = |(fifo_full_i & ch_oh);
   assign sel_enough = |(fifo_enough_i & ch_oh);

   always_comb begin
      state_d   = state_q;
      rem_d     = rem_q;
      ch_d      = ch_q;
      fifo_we_d = '0;
      cpu_we_d  = 1'b0;
      drop_inc  = 1'b0;
      ovf_inc   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (we_i) begin
               ch_d  = hdr_ch;
               rem_d = hdr_len;
               if (hdr_len != '0) begin
                  unique case (1'b1)
                     hdr_cpu: state_d = CPU_PL;
                     !hdr_cpu && !hdr_bad: state_d = FIFO_PL;
                     !hdr_cpu && hdr_bad: begin
                        state_d  = DISCARD;
                        drop_inc = 1'b1;
                     end
                  endcase
               end
            end
         end
         FIFO_PL: begin
            if (we_i) begin
               rem_d = rem_q - 1'b1;
               if (last_word) state_d = IDLE;
               if (sel_full) ovf_inc = 1'b1;
               else          fifo_we_d = ch_oh;
            end
         end
         CPU_PL: begin
            if (we_i) begin
               rem_d = rem_q - 1'b1;
               if (last_word) state_d = IDLE;
               if (cpu_full_i) ovf_inc = 1'b1;
               else            cpu_we_d = 1'b1;
            end
         end
         DISCARD: begin
            if (we_i) begin
               rem_d = rem_q - 1'b1;
               if (last_word) state_d = IDLE;
            end
         end
      endcase
   end

   always_comb begin
      full_o   = 1'b0;
      enough_o = 1'b0;
      unique case (state_q)
         FIFO_PL: begin
            full_o   = sel_full;
            enough_o = sel_enough;
         end
         CPU_PL:  full_o = cpu_full_i;
         IDLE, DISCARD: begin
            full_o   = 1'b0;
            enough_o = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         rem_q       <= '0;
         ch_q        <= '0;
         fifo_we_q   <= '0;
         cpu_we_q    <= 1'b0;
         fifo_data_q <= '0;
         cpu_data_q  <= '0;
         drop_q      <= '0;
         ovf_q       <= '0;
      end else begin
         state_q   <= state_d;
         rem_q     <= rem_d;
         ch_q      <= ch_d;
         fifo_we_q <= fifo_we_d;
         cpu_we_q  <= cpu_we_d;
         if (we_i) begin
            fifo_data_q <= {data_i[QSTART_BIT_INDEX+HALF-1:QSTART_BIT_INDEX],
                            data_i[HALF-1:0]};
            cpu_data_q  <= data_i;
         end
         if (cnt_clr_i) drop_q <= '0;
         else if (drop_inc && drop_q != '1) drop_q <= drop_q + 1'b1;
         if (cnt_clr_i) ovf_q <= '0;
         else if (ovf_inc && ovf_q != '1) ovf_q <= ovf_q + 1'b1;
      end
   end

   assign fifo_we_o   = fifo_we_q;
   assign cpu_we_o    = cpu_we_q;
   assign fifo_data_o = fifo_data_q;
   assign cpu_data_o  = cpu_data_q;
   assign busy_o      = state_q != IDLE;
   assign cur_ch_o    = ch_q;
   assign drop_cnt_o  = drop_q;
   assign ovf_cnt_o   = ovf_q;

endmodule

// File: doc/ft_stream_demux.md
# ft_stream_demux

Parametrised successor to the FTDI-side stream selector. It sits between the FTDI receive interface and the TX sample path. It decodes a header word that selects one of NUM_CH IQ sample FIFOs or the embedded-CPU port, then forwards exactly the announced number of payload words to that destination. Beyond that, it adds per-destination backpressure reporting, discard of packets addressed to non-existent channels, and saturating drop/overflow counters readable by the CPU.

## Interface
- FT_DATA_WIDTH, 32: FTDI word width.
- IQ_PAIR_WIDTH, 24: packed I/Q width written to sample FIFOs.
- QSTART_BIT_INDEX, 16: LSB of the Q half inside an FTDI word.
- NUM_CH, 4: number of IQ FIFO channels (1..8).
- LEN_WIDTH, 16: payload length field width (header bits [LEN_WIDTH-1:0]).
- CNT_WIDTH, 8: width of the drop and overflow counters.

Ports:
- clk_i  in  1  FTDI-domain clock; the only clock.
- reset_n  in  1  synchronous, active-low reset.
- data_i  in  FT_DATA_WIDTH  FTDI word.
- we_i  in  1  data_i valid this cycle.
- full_o  out  1  currently selected destination cannot accept a word.
- enough_o  out  1  selected FIFO channel reports its enough level.
- fifo_full_i  in  NUM_CH  per-channel full.
- fifo_enough_i  in  NUM_CH  per-channel enough level.
- fifo_data_o  out  IQ_PAIR_WIDTH  shared data to all FIFOs: {data_i[QSTART_BIT_INDEX+IQ_PAIR_WIDTH/2-1:QSTART_BIT_INDEX], data_i[IQ_PAIR_WIDTH/2-1:0]}, registered.
- fifo_we_o  out  NUM_CH  one-hot write strobe.
- cpu_full_i  in  1  CPU port full.
- cpu_data_o  out  FT_DATA_WIDTH  registered copy of data_i.
- cpu_we_o  out  1  CPU write strobe.
- cnt_clr_i  in  1  synchronous clear of both counters.
- busy_o  out  1  a packet is in progress (state ≠ IDLE).
- cur_ch_o  out  3  channel field of the last accepted header.
- drop_cnt_o  out  CNT_WIDTH  packets discarded (bad channel), saturating.
- ovf_cnt_o  out  CNT_WIDTH  payload words lost to a full destination, saturating.

## Operation
- Header, decoded in IDLE when we_i=1:
  - bit[FT_DATA_WIDTH-1] selects the destination: 0 = FIFO, 1 = CPU.
  - bits[FT_DATA_WIDTH-2:FT_DATA_WIDTH-4] give the channel.
  - bits[LEN_WIDTH-1:0] give N, the number of payload words that follow.
- States: IDLE, FIFO_PL, CPU_PL, DISCARD. Headers are never forwarded.
- IDLE + header, by case:
  - N=0: stay IDLE; header-only packet, no effect except cur_ch_o update.
  - CPU bit set: go to CPU_PL.
  - FIFO with channel < NUM_CH: go to FIFO_PL.
  - FIFO with channel ≥ NUM_CH: go to DISCARD and increment drop_cnt_o.
- Remaining-count register loads N. Each we_i=1 payload cycle decrements it. The word that makes it 0 (remaining==1) returns the FSM to IDLE on the same edge. Any N up to 2^LEN_WIDTH−1 is valid.
- In FIFO_PL, a payload word with fifo_full_i[ch]=0 produces a fifo_we_o[ch] pulse. In CPU_PL, a payload word with cpu_full_i=0 produces a cpu_we_o pulse.
- A payload word arriving while the destination is full is dropped. It still decrements the remaining count, so framing is kept, and ovf_cnt_o increments.
- DISCARD consumes words silently.
- Both counters saturate at 2^CNT_WIDTH−1. cnt_clr_i wins over a simultaneous increment (result 0).
- full_o (combinational):
  - IDLE and DISCARD: 0.
  - FIFO_PL: fifo_full_i[ch].
  - CPU_PL: cpu_full_i.
- enough_o (combinational): fifo_enough_i[ch] in FIFO_PL, else 0.
- Reset (reset_n=0 at a clk_i edge), including mid-packet:
  - FSM to IDLE, remaining count to 0.
  - All strobes, data outputs, cur_ch_o and both counters to 0.
  - busy_o=0, full_o=0, enough_o=0.
  - The remainder of an interrupted packet is then parsed as headers.

## Timing
- Header accepted at edge T; the first payload word may arrive in the cycle immediately after (edge T+1). No idle gap is required.
- Payload word sampled at edge P → fifo_data_o/cpu_data_o valid and the strobe high for exactly the cycle after P (1-cycle latency).
- Back-to-back payload words give continuous strobes.
- The last payload word at edge L; the next word may be a header sampled at edge L+1.
- we_i=0 cycles hold state; strobes are 0 in those output cycles.
- busy_o rises the cycle after a header with N>0 and falls the cycle after the last payload word.
- Counters update one cycle after the triggering word.

## Test plan
- Reset, then header 0x0000_0003 plus words 0x0011_0022, 0x0033_0044, 0x0055_0066 back-to-back → fifo_we_o=0001 for 3 consecutive cycles; fifo_data_o=0x011022, 0x033044, 0x055066; busy_o falls after the third word.
- Header 0x8000_0002 plus 2 words → cpu_we_o pulses twice with the exact 32-bit words; no fifo_we_o activity.
- Header for channel 5 (NUM_CH=4), N=4, plus 4 words → no strobes, drop_cnt_o=1; the next valid header is decoded normally.
- Channel 2, N=4, fifo_full_i[2]=1 during the 2nd and 3rd words → exactly 2 writes, ovf_cnt_o=2, full_o=1 during the full cycles; returns to IDLE after 4 words.
- Header with N=0 followed immediately by header 0x1000_0001 plus 1 word → single write on channel 1.
- reset_n=0 for one cycle mid-payload (2 of 5 words sent) → outputs 0, IDLE; the next word is treated as a header. Also: 300 bad packets → drop_cnt_o saturates at 255, and cnt_clr_i clears it to 0.
